tl_monitor: RTL and testbench
=============================

// Module: tl_monitor
// PURPOSE
//  Watchdog on the far end of the lamp interface. Samples the green/yellow/red lamp lines
//  driven by the traffic-light controller and checks that exactly one lamp is lit.
//  Checks the legal order R->G->Y->R and each phase's duration in 1 s ticks.
//  Any violation raises a fault with an error code; it is held until cleared.
// PARAMETERS
//  CLK_HZ      50_000_000  clk cycles per 1 s tick
//  RED_S       40          nominal red duration, s
//  GREEN_S     21          nominal green duration, s
//  YELLOW_S    3           nominal yellow duration, s
//  TOL_S       1           allowed +/- deviation, s
//  GLITCH_CYC  4           consecutive clk of dark/multi-lamp before a lamp fault
// PORTS
//  clk         in   1  system clock
//  _rst        in   1  asynchronous active-low reset
//  green       in   1  green lamp line
//  yellow      in   1  yellow lamp line
//  red         in   1  red lamp line
//  clr_fault   in   1  1-clk pulse; clears fault, FSM returns to IDLE
//  phase       out  3  tl_pkg::phase_t of current FSM state
//  sec_cnt     out  8  whole ticks elapsed in current phase, saturates at 255
//  fault       out  1  high while FSM is in FAULT
//  err_code    out  2  00 none, 01 sequence, 10 timing, 11 lamp; valid while fault=1
//  cycle_done  out  1  1-clk pulse on each Y->R transition after a fully checked R,G,Y
// BEHAVIOUR
//  Reset (_rst=0, async): all registers 0; phase=IDLE, sec_cnt=0, fault=0, err_code=0, cycle_done=0.
//  Decode: exactly one lamp -> R/G/Y; none or >1 -> INVALID. INVALID for GLITCH_CYC consecutive clks -> err lamp.
//  INVALID shorter than that: the FSM holds its current phase, and sec_cnt keeps counting.
//  Tick: divider counts 0..CLK_HZ-1 and wraps; tick=1 when count==CLK_HZ-1. Divider restarts at 0 on every phase entry.
//  sec_cnt: cleared on phase entry; +1 per tick; saturates at 255.
//  FSM: IDLE, RED, GREEN, YELLOW, FAULT.
//   IDLE -> the first valid lamp's phase. That first phase is "partial": its duration is not checked.
//   RED->GREEN, GREEN->YELLOW and YELLOW->RED are legal.
//   Any other change between valid lamps -> FAULT, err=sequence.
//   On leaving a non-partial phase: legal if NOM-TOL <= sec_cnt <= NOM+TOL, else FAULT, err=timing.
//   Overrun: the tick that would make sec_cnt = NOM+TOL+1 -> FAULT, err=timing, in the same clk.
//   FAULT: holds err_code; lamps are ignored. clr_fault -> IDLE with sec_cnt=0.
//  Latency: the FSM updates the clk after a lamp change is sampled, plus 2 clk if LAMP_SYNC_EN is defined.
//  Simultaneous events:
//   - new error and clr_fault in the same clk: the error wins and FAULT is (re)entered.
//   - priority when two errors coincide: lamp > sequence > timing.
//  Reset mid-phase: the monitor restarts in IDLE, and the next phase is partial.
// CONFIGURATION
//  LAMP_SYNC_EN defined: each lamp input passes a 2-flop synchronizer (reset 0) before decode.
//   Use when the lamps come from another clock domain or a pad.
//  LAMP_SYNC_EN undefined: lamps are decoded directly; inputs must be synchronous to clk.
// STRUCTURE
//  tl_pkg: typedef enum logic[2:0] phase_t {P_IDLE,P_RED,P_GREEN,P_YELLOW,P_FAULT};
//   typedef enum logic[1:0] err_t {E_NONE,E_SEQ,E_TIME,E_LAMP}; lamp-decode function.
//  Sub-module tl_tick_gen: divider with restart input and tick output, parameter CLK_HZ.
//  tl_monitor holds the decode, glitch counter, FSM and sec_cnt.
// TESTING  (CLK_HZ=10, RED_S=4, GREEN_S=3, YELLOW_S=2, TOL_S=1, GLITCH_CYC=4)
//  1 Reset, then R40clk G30 Y20 R40 -> no fault; cycle_done pulse at 2nd Y->R; phase tracks lamps.
//  2 R40 then Y -> fault=1, err_code=01, phase=P_FAULT; clr_fault -> phase=P_IDLE, fault=0.
//   (R40 only: the first phase after IDLE is partial and is not timed.)
//  3 Partial R, G held 60 clk -> fault at tick 5 (sec_cnt=5), err_code=10; G10 then Y -> err_code=10.
//  4 Within R: all lamps off 3 clk -> no fault; 4 clk -> err_code=11. r+g both on for 4 clk -> err_code=11.
//  5 _rst low mid-G for 1 clk -> outputs return to reset values at once; the next phase is not timed.
//  6 Error and clr_fault in the same clk -> fault stays 1. Repeat 1-4 with LAMP_SYNC_EN defined (+2 clk).

Source files
------------

// File: rtl/tl_pkg.sv
// Shared types and lamp helpers for the traffic-light lamp monitor.
package tl_pkg;

  typedef enum logic [2:0] {P_IDLE, P_RED, P_GREEN, P_YELLOW, P_FAULT} phase_t;
  typedef enum logic [1:0] {E_NONE, E_SEQ, E_TIME, E_LAMP} err_t;

  // P_IDLE doubles as "invalid": all lamps dark or more than one lit.
  function automatic phase_t lamp_decode(input logic green, input logic yellow,
                                         input logic red);
    case ({red, green, yellow})
      3'b100:  return P_RED;
      3'b010:  return P_GREEN;
      3'b001:  return P_YELLOW;
      default: return P_IDLE;
    endcase
  endfunction

  function automatic phase_t next_legal(input phase_t p);
    case (p)
      P_RED:    return P_GREEN;
      P_GREEN:  return P_YELLOW;
      P_YELLOW: return P_RED;
      default:  return P_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// One-second tick divider; restart forces the count back to zero.
module tl_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic _rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(CLK_HZ - 1));

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst)                cnt <= '0;
    else if (restart || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/tl_monitor.sv
// Lamp-interface watchdog: checks one-hot lamps, R->G->Y order and phase durations.
// Define LAMP_SYNC_EN to put a 2-flop synchronizer on each lamp input (+2 clk latency).
//
//  state    | meaning
//  P_IDLE   | waiting for the first valid lamp; that phase is untimed
//  P_RED    | red lit
//  P_GREEN  | green lit
//  P_YELLOW | yellow lit
//  P_FAULT  | violation latched in err_code until clr_fault
module tl_monitor
  import tl_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int RED_S      = 40,
  parameter int GREEN_S    = 21,
  parameter int YELLOW_S   = 3,
  parameter int TOL_S      = 1,
  parameter int GLITCH_CYC = 4
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic       green,
  input  logic       yellow,
  input  logic       red,
  input  logic       clr_fault,
  output logic [2:0] phase,
  output logic [7:0] sec_cnt,
  output logic       fault,
  output logic [1:0] err_code,
  output logic       cycle_done
);

  localparam int GW = $clog2(GLITCH_CYC + 1);

  logic [2:0]    lamps;
  phase_t        state, dec, nxt;
  err_t          err;
  logic          invalid, active, changed, in_range, overrun;
  logic          lamp_err, seq_err, time_err;
  logic          tick, restart, partial, chk_r, chk_g;
  logic [GW-1:0] glitch_cnt;
  logic [7:0]    sec_inc;
  int            nom;

`ifdef LAMP_SYNC_EN
  logic [2:0] sync1, sync2;
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {green, yellow, red};
      sync2 <= sync1;
    end
  end
  assign lamps = sync2;
`else
  assign lamps = {green, yellow, red};
`endif

  always_comb begin
    dec     = lamp_decode(lamps[2], lamps[1], lamps[0]);
    invalid = (dec == P_IDLE);
    active  = (state == P_RED) || (state == P_GREEN) || (state == P_YELLOW);
    changed = active && !invalid && (dec != state);
    case (state)
      P_RED:    nom = RED_S;
      P_GREEN:  nom = GREEN_S;
      P_YELLOW: nom = YELLOW_S;
      default:  nom = 0;
    endcase
    in_range = (int'(sec_cnt) >= nom - TOL_S) && (int'(sec_cnt) <= nom + TOL_S);
    overrun  = tick && (int'(sec_cnt) == nom + TOL_S);
    lamp_err = (state != P_FAULT) && invalid && (glitch_cnt == GW'(GLITCH_CYC - 1));
    seq_err  = changed && (dec != next_legal(state));
    time_err = active && !partial && (overrun || (changed && !in_range));
    if (lamp_err)      err = E_LAMP;
    else if (seq_err)  err = E_SEQ;
    else if (time_err) err = E_TIME;
    else               err = E_NONE;
    nxt = state;
    if (err != E_NONE) nxt = P_FAULT;
    else begin
      case (state)
        P_IDLE:  if (!invalid) nxt = dec;
        P_FAULT: if (clr_fault) nxt = P_IDLE;
        default: if (changed) nxt = dec;
      endcase
    end
    sec_inc = (sec_cnt == 8'hFF) ? sec_cnt : sec_cnt + 8'(tick);
  end

  assign restart = (nxt != state);
  assign phase   = state;

  tl_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    ._rst   (_rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state      <= P_IDLE;
      sec_cnt    <= '0;
      fault      <= 1'b0;
      err_code   <= '0;
      cycle_done <= 1'b0;
      partial    <= 1'b0;
      chk_r      <= 1'b0;
      chk_g      <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state      <= nxt;
      fault      <= (nxt == P_FAULT);
      cycle_done <= 1'b0;
      if (state == P_FAULT || !invalid)
        glitch_cnt <= '0;
      else if (glitch_cnt != GW'(GLITCH_CYC - 1))
        glitch_cnt <= glitch_cnt + 1'b1;
      if (err != E_NONE) begin
        // sec_cnt freezes on the value that triggered the fault.
        err_code <= err;
        sec_cnt  <= sec_inc;
        partial  <= 1'b0;
        chk_r    <= 1'b0;
        chk_g    <= 1'b0;
      end else begin
        case (state)
          P_FAULT: if (clr_fault) begin
            err_code <= E_NONE;
            sec_cnt  <= '0;
          end
          P_IDLE: if (!invalid) begin
            sec_cnt <= '0;
            partial <= 1'b1;
            chk_r   <= 1'b0;
            chk_g   <= 1'b0;
          end else sec_cnt <= sec_inc;
          default: if (changed) begin
            sec_cnt <= '0;
            partial <= 1'b0;
            if (!partial) begin
              if (state == P_RED)   chk_r <= 1'b1;
              if (state == P_GREEN) chk_g <= 1'b1;
              if (state == P_YELLOW) begin
                cycle_done <= chk_r && chk_g;
                chk_r      <= 1'b0;
                chk_g      <= 1'b0;
              end
            end
          end else sec_cnt <= sec_inc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tl_monitor.sv
// Directed bench for tl_monitor with a 10-clk second and short nominal phases.
module tb_tl_monitor;
  import tl_pkg::*;

`ifdef LAMP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       green = 1'b0, yellow = 1'b0, red = 1'b0, clr_fault = 1'b0;
  logic [2:0] phase;
  logic [7:0] sec_cnt;
  logic       fault;
  logic [1:0] err_code;
  logic       cycle_done;
  int         n_total = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  tl_monitor #(
    .CLK_HZ(10), .RED_S(4), .GREEN_S(3), .YELLOW_S(2), .TOL_S(1), .GLITCH_CYC(4)
  ) dut (
    .clk       (clk),
    ._rst      (rst),
    .green     (green),
    .yellow    (yellow),
    .red       (red),
    .clr_fault (clr_fault),
    .phase     (phase),
    .sec_cnt   (sec_cnt),
    .fault     (fault),
    .err_code  (err_code),
    .cycle_done(cycle_done)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lamps(input logic g, input logic y, input logic r);
    green  = g;
    yellow = y;
    red    = r;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Hold the current lamp n clk from phase entry, then switch and wait for the FSM.
  task automatic step(input logic g, input logic y, input logic r, input int n);
    cyc(n - 1);
    lamps(g, y, r);
    cyc(1 + LAT);
  endtask

  task automatic clear_to_red();
    lamps(1'b0, 1'b0, 1'b1);
    cyc(LAT + 1);
    clr_fault = 1'b1;
    cyc(1);
    clr_fault = 1'b0;
    chk("clr_idle", 8'(phase), 8'(P_IDLE));
    chk("clr_fault0", 8'(fault), 8'd0);
    cyc(1);
    chk("clr_red", 8'(phase), 8'(P_RED));
  endtask

  initial begin
    lamps(1'b0, 1'b0, 1'b1);
    #1 rst = 1'b0;
    cyc(2);
    chk("rst_phase", 8'(phase), 8'(P_IDLE));
    chk("rst_sec", sec_cnt, 8'd0);
    chk("rst_fault", 8'(fault), 8'd0);
    chk("rst_err", 8'(err_code), 8'd0);
    chk("rst_done", 8'(cycle_done), 8'd0);
    rst = 1'b1;

    // 1: two legal cycles
    cyc(1 + LAT);
    chk("t1_red", 8'(phase), 8'(P_RED));
    cyc(39);
    lamps(1'b1, 1'b0, 1'b0);
    cyc(1 + LAT);
    chk("t1_green", 8'(phase), 8'(P_GREEN));
    cyc(25);
    chk("t1_sec2", sec_cnt, 8'd2);
    cyc(4);
    lamps(1'b0, 1'b1, 1'b0);
    cyc(1 + LAT);
    chk("t1_yellow", 8'(phase), 8'(P_YELLOW));
    step(1'b0, 1'b0, 1'b1, 20);
    chk("t1_red2", 8'(phase), 8'(P_RED));
    chk("t1_no_done", 8'(cycle_done), 8'd0);
    step(1'b1, 1'b0, 1'b0, 40);
    step(1'b0, 1'b1, 1'b0, 30);
    step(1'b0, 1'b0, 1'b1, 20);
    chk("t1_done", 8'(cycle_done), 8'd1);
    chk("t1_nofault", 8'(fault), 8'd0);
    cyc(1);
    chk("t1_done_pulse", 8'(cycle_done), 8'd0);

    // 2: R -> Y sequence error
    step(1'b0, 1'b1, 1'b0, 40);
    chk("t2_fault", 8'(fault), 8'd1);
    chk("t2_err", 8'(err_code), 8'd1);
    chk("t2_phase", 8'(phase), 8'(P_FAULT));
    clear_to_red();

    // 3: green overrun, then green too short
    step(1'b1, 1'b0, 1'b0, 10);
    cyc(49);
    chk("t3_sec4", sec_cnt, 8'd4);
    chk("t3_nofault", 8'(fault), 8'd0);
    cyc(1);
    chk("t3_fault", 8'(fault), 8'd1);
    chk("t3_err", 8'(err_code), 8'd2);
    chk("t3_sec5", sec_cnt, 8'd5);
    clear_to_red();
    step(1'b1, 1'b0, 1'b0, 10);
    step(1'b0, 1'b1, 1'b0, 10);
    chk("t3_short_fault", 8'(fault), 8'd1);
    chk("t3_short_err", 8'(err_code), 8'd2);

    // 4: lamp glitches
    clear_to_red();
    cyc(5);
    lamps(1'b0, 1'b0, 1'b0);
    cyc(3);
    lamps(1'b0, 1'b0, 1'b1);
    cyc(2 + LAT);
    chk("t4_dark3_ok", 8'(fault), 8'd0);
    chk("t4_dark3_red", 8'(phase), 8'(P_RED));
    lamps(1'b0, 1'b0, 1'b0);
    cyc(3 + LAT);
    chk("t4_dark_pre", 8'(fault), 8'd0);
    cyc(1);
    chk("t4_dark4_fault", 8'(fault), 8'd1);
    chk("t4_dark4_err", 8'(err_code), 8'd3);
    clear_to_red();
    cyc(5);
    lamps(1'b1, 1'b0, 1'b1);
    cyc(3 + LAT);
    chk("t4_multi_pre", 8'(fault), 8'd0);
    cyc(1);
    chk("t4_multi_fault", 8'(fault), 8'd1);
    chk("t4_multi_err", 8'(err_code), 8'd3);

    // 5: reset mid-green, next phase untimed
    clear_to_red();
    step(1'b1, 1'b0, 1'b0, 40);
    cyc(25);
    chk("t5_sec2", sec_cnt, 8'd2);
    rst = 1'b0;
    #1;
    chk("t5_rst_phase", 8'(phase), 8'(P_IDLE));
    chk("t5_rst_sec", sec_cnt, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1 + LAT);
    chk("t5_green", 8'(phase), 8'(P_GREEN));
    cyc(59);
    chk("t5_long_ok", 8'(fault), 8'd0);
    chk("t5_sec5", sec_cnt, 8'd5);
    cyc(1);
    lamps(1'b0, 1'b1, 1'b0);
    cyc(1 + LAT);
    chk("t5_yellow", 8'(phase), 8'(P_YELLOW));
    chk("t5_untimed", 8'(fault), 8'd0);

    // 6: error coincides with clr_fault
    lamps(1'b1, 1'b0, 1'b0);
    cyc(LAT);
    clr_fault = 1'b1;
    cyc(1);
    clr_fault = 1'b0;
    chk("t6_fault", 8'(fault), 8'd1);
    chk("t6_err", 8'(err_code), 8'd1);
    chk("t6_phase", 8'(phase), 8'(P_FAULT));
    cyc(3);
    chk("t6_hold", 8'(fault), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
